// File: rtl/alarm_ctrl_if.sv
// Bus bundle between the sensor/keypad side and the intrusion controller.
// The master drives requests and the alarm line; the controller (slave) drives status.
interface alarm_ctrl_if;
    logic       arm;
    logic       disarm;
    logic       trig;
    logic       siren;
    logic       armed;
    logic [2:0] state;
    logic [3:0] alarm_cnt;

    modport master (
        output arm,
        output disarm,
        output trig,
        input  siren,
        input  armed,
        input  state,
        input  alarm_cnt
    );

    modport slave (
        input  arm,
        input  disarm,
        input  trig,
        output siren,
        output armed,
        output state,
        output alarm_cnt
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Timed intrusion controller: arm/disarm, exit delay, trigger debounce, entry delay,
// timed siren with auto re-arm, and a saturating count of siren activations.
module alarm_ctrl #(
    parameter int EXIT_CYC  = 8,
    parameter int ENTRY_CYC = 4,
    parameter int SIREN_CYC = 16,
    parameter int DEB       = 2
) (
    input  logic        clk,
    input  logic        rst,
    alarm_ctrl_if.slave bus
);

    localparam int MAX_AB  = (EXIT_CYC > ENTRY_CYC) ? EXIT_CYC : ENTRY_CYC;
    localparam int MAX_CYC = (MAX_AB > SIREN_CYC) ? MAX_AB : SIREN_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam int DW      = $clog2(DEB + 1);

    // The timer counts up from zero on state entry; these are the last cycle of each stay.
    localparam logic [TW-1:0] EXIT_LAST  = TW'(EXIT_CYC - 1);
    localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_CYC - 1);
    localparam logic [TW-1:0] SIREN_LAST = TW'(SIREN_CYC - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [DW-1:0] DEB_ONE    = DW'(1);

    typedef enum logic [2:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_SIREN       = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_s;
    logic [DW-1:0] deb_r;
    logic [DW-1:0] deb_s;
    logic          siren_r;
    logic          armed_r;
    logic [3:0]    alarm_cnt_r;
    logic          siren_entry_s;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        logic [3:0] result;
        if (value == 4'd15) begin
            result = 4'd15;
        end else begin
            result = value + 4'd1;
        end
        return result;
    endfunction

    function automatic logic state_is_armed(input state_t s);
        logic result;
        case (s)
            ST_ARMED, ST_ENTRY_DELAY, ST_SIREN: result = 1'b1;
            default:                            result = 1'b0;
        endcase
        return result;
    endfunction

    // Next-state, shared timer and debounce counter; disarm overrides every state.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        deb_s   = '0;
        if (bus.disarm) begin
            state_s = ST_DISARMED;
            timer_s = '0;
            deb_s   = '0;
        end else begin
            case (state_r)
                ST_DISARMED: begin
                    timer_s = '0;
                    if (bus.arm) begin
                        state_s = ST_EXIT_DELAY;
                    end else begin
                        state_s = ST_DISARMED;
                    end
                end
                ST_EXIT_DELAY: begin
                    if (timer_r == EXIT_LAST) begin
                        state_s = ST_ARMED;
                        timer_s = '0;
                    end else begin
                        timer_s = timer_r + TIMER_ONE;
                    end
                end
                ST_ARMED: begin
                    timer_s = '0;
                    if (!bus.trig) begin
                        deb_s = '0;
                    end else if (deb_r == DEB_LAST) begin
                        state_s = ST_ENTRY_DELAY;
                        deb_s   = '0;
                    end else begin
                        deb_s = deb_r + DEB_ONE;
                    end
                end
                ST_ENTRY_DELAY: begin
                    if (timer_r == ENTRY_LAST) begin
                        state_s = ST_SIREN;
                        timer_s = '0;
                    end else begin
                        timer_s = timer_r + TIMER_ONE;
                    end
                end
                ST_SIREN: begin
                    if (timer_r == SIREN_LAST) begin
                        state_s = ST_ARMED;
                        timer_s = '0;
                    end else begin
                        timer_s = timer_r + TIMER_ONE;
                    end
                end
                default: begin
                    state_s = ST_DISARMED;
                    timer_s = '0;
                end
            endcase
        end
    end

    // SIREN can only be entered from ENTRY_DELAY, so this pulses once per activation.
    always_comb begin
        siren_entry_s = 1'b0;
        if ((state_s == ST_SIREN) && (state_r != ST_SIREN)) begin
            siren_entry_s = 1'b1;
        end else begin
            siren_entry_s = 1'b0;
        end
    end

    // State, timer and debounce registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_DISARMED;
            timer_r <= '0;
            deb_r   <= '0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            deb_r   <= deb_s;
        end
    end

    // Outputs are registered from the next state so they change together with state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            siren_r     <= 1'b0;
            armed_r     <= 1'b0;
            alarm_cnt_r <= 4'd0;
        end else begin
            siren_r <= (state_s == ST_SIREN);
            armed_r <= state_is_armed(state_s);
            if (siren_entry_s) begin
                alarm_cnt_r <= sat_inc4(alarm_cnt_r);
            end else begin
                alarm_cnt_r <= alarm_cnt_r;
            end
        end
    end

    assign bus.siren     = siren_r;
    assign bus.armed     = armed_r;
    assign bus.state     = state_r;
    assign bus.alarm_cnt = alarm_cnt_r;

endmodule
